// File: rtl/note_octave_divider.sv
// note_octave_divider: sequential restoring divider that splits a note index
// into octave (quotient) and step within the octave (remainder). The divisor is
// supplied at run time. A tag travels with each request and comes back with
// its result. Handshake is valid/ready on both sides, one request in flight.
module note_octave_divider #(
  parameter int NUM_W = 6,
  parameter int DEN_W = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] in_num,
  input  logic [DEN_W-1:0] in_den,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] out_quot,
  output logic [DEN_W-1:0] out_rem,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div0
);

  localparam int CNT_W = $clog2(NUM_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [NUM_W-1:0] num_reg;   // numerator, shifted left one bit per step
  logic [DEN_W-1:0] den_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [DEN_W:0]   p_reg;     // partial remainder, one guard bit wide
  logic [NUM_W-1:0] q_reg;     // quotient bits collected so far
  logic             div0_reg;  // captured request had a zero divisor

  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   den_ext;
  logic             qbit;
  logic [DEN_W:0]   p_next;
  logic [NUM_W-1:0] q_next;

  // Handshake flags are pure functions of state, never of the partner's valid/ready.
  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);

  // One restoring step: bring in the next numerator bit, subtract if it fits.
  always_comb begin
    trial   = {p_reg[DEN_W-1:0], num_reg[NUM_W-1]};
    den_ext = {1'b0, den_reg};
    qbit    = (trial >= den_ext);
    p_next  = qbit ? (trial - den_ext) : trial;
    q_next  = {q_reg[NUM_W-2:0], qbit};
  end

  // Control FSM, working registers and the held result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      num_reg   <= '0;
      den_reg   <= '0;
      tag_reg   <= '0;
      p_reg     <= '0;
      q_reg     <= '0;
      div0_reg  <= 1'b0;
      out_quot  <= '0;
      out_rem   <= '0;
      out_tag   <= '0;
      out_div0  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            num_reg   <= in_num;
            den_reg   <= in_den;
            tag_reg   <= in_tag;
            p_reg     <= '0;
            q_reg     <= '0;
            div0_reg  <= (in_den == '0);
            // A zero divisor still spends one edge in CALC so its result
            // appears one edge after acceptance, like a one-step division.
            cnt_reg   <= (in_den == '0) ? '0 : CNT_W'(NUM_W - 1);
            state_reg <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (div0_reg) begin
            out_quot  <= '1;
            out_rem   <= num_reg[DEN_W-1:0];
            out_tag   <= tag_reg;
            out_div0  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            p_reg   <= p_next;
            q_reg   <= q_next;
            num_reg <= {num_reg[NUM_W-2:0], 1'b0};
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
              out_quot  <= q_next;
              out_rem   <= p_next[DEN_W-1:0];
              out_tag   <= tag_reg;
              out_div0  <= 1'b0;
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Retire only; the earliest next accept is the following edge.
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_octave_divider.sv
// tb_note_octave_divider: directed checks of the note/octave divider with
// hand-computed results, plus an all-operands sweep against / and %.
module tb_note_octave_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  // default 6/4/3 instance
  logic       in_valid, in_ready, out_valid, out_ready, out_div0;
  logic [5:0] in_num, out_quot;
  logic [3:0] in_den, out_rem;
  logic [2:0] in_tag, out_tag;
  // wide 8/4/3 instance
  logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_div0;
  logic [7:0] w_in_num, w_out_quot;
  logic [3:0] w_in_den, w_out_rem;
  logic [2:0] w_in_tag, w_out_tag;

  int tests_run = 0;
  int tests_failed = 0;

  note_octave_divider #(.NUM_W(6), .DEN_W(4), .TAG_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_den(in_den), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem), .out_tag(out_tag), .out_div0(out_div0)
  );

  note_octave_divider #(.NUM_W(8), .DEN_W(4), .TAG_W(3)) dut_wide (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_num(w_in_num), .in_den(w_in_den), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_quot(w_out_quot), .out_rem(w_out_rem), .out_tag(w_out_tag), .out_div0(w_out_div0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request; the edge inside this task is the accepting edge.
  task automatic send(input logic [5:0] n, input logic [3:0] d, input logic [2:0] t);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check("send_ready", in_ready, 1);
    in_num   = n;
    in_den   = d;
    in_tag   = t;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid is seen (bounded).
  task automatic wait_result(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin
      step();
      edges++;
    end
  endtask

  initial begin
    int e;
    int stall;
    int acc [2];
    int k;

    reset = 1'b1;
    in_valid = 1'b0; in_num = '0; in_den = '0; in_tag = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_num = '0; w_in_den = '0; w_in_tag = '0; w_out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_quot", out_quot, 0);
    check("rst_out_rem", out_rem, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_div0", out_div0, 0);

    // 47 / 12, tag 5: 3 rem 11 after exactly 6 edges
    send(6'd47, 4'd12, 3'd5);
    check("busy_in_ready", in_ready, 0);
    wait_result(e);
    $display("[TB] txn 47/12 tag=5 -> quot=%0d rem=%0d tag=%0d div0=%0d edges=%0d",
             out_quot, out_rem, out_tag, out_div0, e);
    check("lat_47_12", e, 6);
    check("quot_47_12", out_quot, 3);
    check("rem_47_12", out_rem, 11);
    check("tag_47_12", out_tag, 5);
    check("div0_47_12", out_div0, 0);

    // hold in DONE for 10 cycles with a competing request that must be ignored
    in_valid = 1'b1; in_num = 6'd9; in_den = 4'd2; in_tag = 3'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_quot", out_quot, 3);
      check("hold_rem", out_rem, 11);
      check("hold_tag", out_tag, 5);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("retire_valid", out_valid, 0);
    check("retire_in_ready", in_ready, 1);
    check("retire_keep_quot", out_quot, 3);

    // 40 / 0: one edge, all-ones quotient, low numerator bits as remainder
    send(6'd40, 4'd0, 3'd6);
    wait_result(e);
    $display("[TB] txn 40/0 tag=6 -> quot=%0d rem=%0d div0=%0d edges=%0d",
             out_quot, out_rem, out_div0, e);
    check("lat_div0", e, 1);
    check("quot_div0", out_quot, 63);
    check("rem_div0", out_rem, 8);
    check("tag_div0", out_tag, 6);
    check("flag_div0", out_div0, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // reset three edges after accepting 63/12: operation dropped
    send(6'd63, 4'd12, 3'd2);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("[TB] txn 63/12 aborted by reset");
    check("abort_in_ready", in_ready, 1);
    check("abort_quot_cleared", out_quot, 0);
    for (int i = 0; i < 10; i++) begin
      check("abort_no_valid", out_valid, 0);
      step();
    end

    // throughput with out_ready tied high and in_valid held: NUM_W+2 cycles
    out_ready = 1'b1;
    in_valid = 1'b1; in_num = 6'd20; in_den = 4'd3; in_tag = 3'd3;
    acc[0] = 0; acc[1] = 0; k = 0;
    for (int c = 0; c < 40 && k < 2; c++) begin
      if (in_ready) begin
        acc[k] = c;
        k++;
      end
      step();
    end
    in_valid = 1'b0;
    $display("[TB] txn 20/3 back-to-back accepts at cycles %0d and %0d", acc[0], acc[1]);
    check("throughput", acc[1] - acc[0], 8);
    wait_result(e);
    check("tp_quot", out_quot, 6);
    check("tp_rem", out_rem, 2);
    step();
    out_ready = 1'b0;

    // all numerators x all nonzero divisors, random consumer stalls
    for (int n = 0; n < 64; n++) begin
      for (int d = 1; d < 16; d++) begin
        send(n[5:0], d[3:0], n[2:0] ^ d[2:0]);
        wait_result(e);
        $display("[TB] txn %0d/%0d -> quot=%0d rem=%0d edges=%0d", n, d, out_quot, out_rem, e);
        check("ex_lat", e, 6);
        check("ex_quot", out_quot, n / d);
        check("ex_rem", out_rem, n % d);
        check("ex_tag", out_tag, n[2:0] ^ d[2:0]);
        stall = $urandom_range(0, 3);
        repeat (stall) step();
        check("ex_stall_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ex_retire", out_valid, 0);
      end
    end

    // wide instance: 255 / 7 = 36 rem 3 exactly 8 edges after accept
    w_in_num = 8'd255; w_in_den = 4'd7; w_in_tag = 3'd4; w_in_valid = 1'b1;
    check("w_ready", w_in_ready, 1);
    step();
    w_in_valid = 1'b0;
    e = 0;
    while (!w_out_valid && e < 50) begin
      step();
      e++;
    end
    $display("[TB] txn wide 255/7 -> quot=%0d rem=%0d edges=%0d", w_out_quot, w_out_rem, e);
    check("w_lat", e, 8);
    check("w_quot", w_out_quot, 36);
    check("w_rem", w_out_rem, 3);
    check("w_tag", w_out_tag, 4);
    check("w_div0", w_out_div0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
